cpu_ctrl16: RTL and testbench
=============================

# cpu_ctrl16

Multi-cycle control and execute stage directly upstream of the 16-entry × 16-bit register file. It accepts one instruction per handshake and decodes it. It drives the register file's read addresses, consumes the registered read data one cycle later, and computes the result in an internal ALU. It then issues a single-cycle write back into the register file.

## Interface
- `DATA_W`, default 16: datapath and instruction width.
- `RADDR_W`, default 4: register address width (16 registers).
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `instr` in 16: instruction word, sampled on handshake.
- `instr_valid` in 1: upstream has an instruction.
- `instr_ready` out 1: block can accept; transfer occurs when `instr_valid && instr_ready`.
- `rf_write` out 1: register-file write enable.
- `rf_wr_addr` out 4: destination register.
- `rf_wr_data` out 16: write data.
- `rf_rd_addr_a` / `rf_rd_addr_b` out 4: source addresses.
- `rf_rd_data_a` / `rf_rd_data_b` in 16: register-file read data, valid one cycle after the addresses are presented with `rf_write=0`.
- `flag_z` / `flag_c` out 1: zero and carry flags.
- `halted` out 1: HALT executed.
- `illegal` out 1: one-cycle pulse on an undefined opcode.

## Operation
- Instruction format:
  - `[15:12]` opcode.
  - `[11:8]` rd.
  - `[7:4]` ra.
  - `[3:0]` rb.
  - `[7:0]` imm8 for LDI.
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=ra+rb.
  - 2 SUB: rd=ra-rb.
  - 3 AND.
  - 4 OR.
  - 5 LDI: rd=sign-extended imm8.
  - 6 MOV: rd=ra.
  - F HALT.
  - 7–E undefined.
- States and transitions:
  - IDLE: handshake → DECODE.
  - DECODE:
    - ALU ops and MOV → READ.
    - LDI → WB.
    - NOP → IDLE.
    - HALT → HALT.
    - Undefined → IDLE.
  - READ → EXEC → WB → IDLE.
  - HALT is absorbing until reset.
- IR is latched on the handshake. `rf_rd_addr_a/b` = IR ra/rb, held constant from DECODE through WB.
- `rf_write` = (state==WB) && !reset. `rf_write` is 0 in every other state, so the register file performs reads in all non-WB cycles.
- EXEC samples `rf_rd_data_a/b`, computes the result into the result register and updates the flags:
  - ADD/SUB/AND/OR update Z (result==0).
  - ADD/SUB update C. ADD: carry-out of the 17-bit sum. SUB: borrow, set when ra<rb unsigned.
  - MOV and LDI leave the flags unchanged.
- Arithmetic is 16-bit modulo 2^16.
- `rf_wr_data` = result register (LDI loads sign-extended imm8 into it in DECODE). `rf_wr_addr` = IR rd.
- Writing rd equal to ra or rb is legal. Reads complete before WB, so sources are the old values.

## Timing
- Reset values:
  - State IDLE.
  - IR, result, `flag_z`, `flag_c`, `halted`, `illegal` all 0.
  - `rf_write` = 0, and is forced 0 in any cycle `reset` is high.
  - `instr_ready` is 0 while `reset` is high and 1 in IDLE otherwise.
- Handshake at edge T. For ALU ops and MOV:
  - DECODE in cycle T+1.
  - READ in T+2.
  - EXEC in T+3, where read data is valid.
  - WB in T+4: `rf_write`=1, write at the end of T+4.
  - IDLE with `instr_ready`=1 in T+5.
- LDI: WB in T+2, ready again in T+3.
- NOP and undefined opcodes: ready again in T+2.
- `instr_ready` is low in all non-IDLE states. `instr` and `instr_valid` are ignored there.
- `illegal` pulses during the DECODE cycle.
- `halted` rises in the cycle after DECODE of HALT.
- Reset mid-operation aborts the instruction. If reset is high during WB, no write occurs. Flags and IR are cleared.

## Configuration
- `CPU_CTRL_ILLEGAL_TRAP_EN`:
  - Defined: an undefined opcode transitions DECODE → HALT, asserts `illegal` for one cycle, and sets `halted`.
  - Undefined: an undefined opcode behaves as NOP, returning to IDLE, and `illegal` still pulses.

## Structure
- Shared package `cpu_pkg` holds:
  - `opcode_e` enum.
  - `ctrl_state_e` enum: IDLE, DECODE, READ, EXEC, WB, HALT.
  - Field-position localparams.
  - `DATA_W` / `RADDR_W` constants, reused by the register file and its bench.
- One sub-module: `alu16`, combinational. Inputs: a, b, op. Outputs: result, zero, carry. Instantiated in EXEC.

## Test plan
- Reset, then LDI r3,#0xFF (0x53FF) → `rf_write`=1 exactly 2 cycles after the handshake, `rf_wr_addr`=3, `rf_wr_data`=0xFFFF.
- Preload r1=0x7FFF and r2=0x0001, then ADD r4,r1,r2 (0x1412) → write in T+4 with data 0x8000, Z=0, C=0. `instr_ready` is low T+1..T+4 and high at T+5.
- r1=5, r2=5, SUB r5,r1,r2 → data 0x0000, Z=1, C=0. Then SUB r6 with r1=3, r2=5 → 0xFFFE, C=1.
- MOV r1,r1 (0x6110) and NOP (0x0000): MOV writes the old value; NOP never asserts `rf_write`; `instr_valid` held high throughout.
- Undefined opcode 0x9000:
  - Without the macro: `illegal` pulses once and the next instruction is accepted at T+2.
  - With the macro: `halted`=1 and `instr_ready` stays 0 until reset.
- Reset asserted during the WB cycle of an ADD → `rf_write`=0 in that cycle, the destination register is unchanged on readback, and IDLE is entered after reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_ctrl16 control/execute stage and its register file:
// opcodes, controller states, instruction field positions and datapath widths.
package cpu_pkg;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 4;

  // Instruction field positions (LSB of each field)
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RA_LSB  = 4;
  localparam int RB_LSB  = 0;
  localparam int IMM_W   = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_LDI  = 4'h5,
    OP_MOV  = 4'h6,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } ctrl_state_e;

  function automatic logic is_defined_op(input logic [3:0] opc);
    return (opc <= 4'h6) || (opc == 4'hF);
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational ALU for cpu_ctrl16: ADD/SUB/AND/OR/MOV with zero and carry/borrow outputs.
import cpu_pkg::*;

module alu16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  opcode_e      op,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         carry
);

  logic [W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = a;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[W-1:0];
        carry  = sum[W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);  // borrow
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = a;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_ctrl16.sv
// Multi-cycle control/execute stage in front of a 16x16 register file.
// Define CPU_CTRL_ILLEGAL_TRAP_EN to make undefined opcodes halt instead of acting as NOP.
import cpu_pkg::*;

module cpu_ctrl16 #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int RADDR_W = cpu_pkg::RADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               rf_write,
  output logic [RADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]  rf_wr_data,
  output logic [RADDR_W-1:0] rf_rd_addr_a,
  output logic [RADDR_W-1:0] rf_rd_addr_b,
  input  logic [DATA_W-1:0]  rf_rd_data_a,
  input  logic [DATA_W-1:0]  rf_rd_data_b,
  output logic               flag_z,
  output logic               flag_c,
  output logic               halted,
  output logic               illegal,
  output ctrl_state_e        dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE, and instr/instr_valid are ignored in every other state.

  ctrl_state_e       state, state_nxt;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] result_q;
  opcode_e           op;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero, alu_carry;
  logic              op_defined;

  assign op         = opcode_e'(ir[OPC_LSB +: 4]);
  assign op_defined = is_defined_op(ir[OPC_LSB +: 4]);

  alu16 #(.W(DATA_W)) u_alu (
    .a      (rf_rd_data_a),
    .b      (rf_rd_data_b),
    .op     (op),
    .result (alu_res),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ir       <= '0;
      result_q <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid)
        ir <= instr;
      if (state == DECODE && op == OP_LDI)
        result_q <= {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
      if (state == EXEC) begin
        result_q <= alu_res;
        // MOV passes through the ALU but leaves both flags alone
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR)
          flag_z <= alu_zero;
        if (op == OP_ADD || op == OP_SUB)
          flag_c <= alu_carry;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (instr_valid) state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: state_nxt = READ;
          OP_LDI:  state_nxt = WB;
          OP_NOP:  state_nxt = IDLE;
          OP_HALT: state_nxt = HALT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          default: state_nxt = HALT;
`else
          default: state_nxt = IDLE;
`endif
        endcase
      end
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  assign instr_ready  = (state == IDLE) && !reset;
  assign rf_write     = (state == WB) && !reset;
  assign illegal      = (state == DECODE) && !op_defined && !reset;
  assign halted       = (state == HALT) && !reset;
  assign rf_wr_addr   = ir[RD_LSB +: RADDR_W];
  assign rf_rd_addr_a = ir[RA_LSB +: RADDR_W];
  assign rf_rd_addr_b = ir[RB_LSB +: RADDR_W];
  assign rf_wr_data   = result_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_cpu_ctrl16.sv
// Directed testbench for cpu_ctrl16 with a behavioural 16x16 register file (registered reads).
// Checks are written for both builds of CPU_CTRL_ILLEGAL_TRAP_EN.
import cpu_pkg::*;

module tb_cpu_ctrl16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        rf_write;
  logic [3:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [3:0]  rf_rd_addr_a, rf_rd_addr_b;
  logic [15:0] rf_rd_data_a, rf_rd_data_b;
  logic        flag_z, flag_c, halted, illegal;
  ctrl_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cpu_ctrl16 dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .rf_write     (rf_write),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .rf_rd_addr_a (rf_rd_addr_a),
    .rf_rd_addr_b (rf_rd_addr_b),
    .rf_rd_data_a (rf_rd_data_a),
    .rf_rd_data_b (rf_rd_data_b),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .halted       (halted),
    .illegal      (illegal),
    .dbg_state    (dbg_state)
  );

  // ---------------- register file model ----------------
  logic [15:0] mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (rf_write) mem[rf_wr_addr] <= rf_wr_data;
    rf_rd_data_a <= mem[rf_rd_addr_a];
    rf_rd_data_b <= mem[rf_rd_addr_b];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  // Issue one instruction from IDLE and walk cycles T+1..T+rdy_k. wb_k=0 means no write expected.
  task automatic run_instr(input string tag, input logic [15:0] ins, input int wb_k,
                           input int rdy_k, input logic [3:0] exp_addr,
                           input logic [15:0] exp_data, input logic exp_ill, input logic keep);
    instr       = ins;
    instr_valid = 1'b1;
    check({tag, "_rdy_pre"}, instr_ready, 1'b1);
    tick();
    if (!keep) instr_valid = 1'b0;
    for (int k = 1; k <= rdy_k; k++) begin
      if (k > 1) tick();
      check($sformatf("%s_rdy_t%0d", tag, k), instr_ready, (k == rdy_k));
      check($sformatf("%s_wr_t%0d", tag, k), rf_write, (k == wb_k));
      check($sformatf("%s_ill_t%0d", tag, k), illegal, (exp_ill && k == 1));
      if (k == wb_k) begin
        check({tag, "_waddr"}, rf_wr_addr, exp_addr);
        check({tag, "_wdata"}, rf_wr_data, exp_data);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 1'b0);
    check("rst_write", rf_write, 1'b0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", instr_ready, 1'b1);
    check("post_rst_z", flag_z, 1'b0);
    check("post_rst_c", flag_c, 1'b0);
    check("post_rst_halted", halted, 1'b0);
    check("post_rst_illegal", illegal, 1'b0);
    check("post_rst_state", dbg_state, IDLE);
    tick();

    // LDI r3,#0xFF -> 0xFFFF, write at T+2
    run_instr("ldi", 16'h53FF, 2, 3, 4'd3, 16'hFFFF, 1'b0, 1'b0);
    check("ldi_mem", mem[3], 16'hFFFF);
    check("ldi_z", flag_z, 1'b0);

    // ADD r4,r1,r2: 0x7FFF + 1
    preload(4'd1, 16'h7FFF);
    preload(4'd2, 16'h0001);
    run_instr("add", 16'h1412, 4, 5, 4'd4, 16'h8000, 1'b0, 1'b0);
    check("add_z", flag_z, 1'b0);
    check("add_c", flag_c, 1'b0);
    check("add_mem", mem[4], 16'h8000);

    // SUB r5 = 5-5, then SUB r6 = 3-5
    preload(4'd1, 16'd5);
    preload(4'd2, 16'd5);
    run_instr("sub0", 16'h2512, 4, 5, 4'd5, 16'h0000, 1'b0, 1'b0);
    check("sub0_z", flag_z, 1'b1);
    check("sub0_c", flag_c, 1'b0);
    preload(4'd1, 16'd3);
    run_instr("subb", 16'h2612, 4, 5, 4'd6, 16'hFFFE, 1'b0, 1'b0);
    check("subb_z", flag_z, 1'b0);
    check("subb_c", flag_c, 1'b1);

    // MOV r1,r1 then NOP with instr_valid held high
    run_instr("mov", 16'h6110, 4, 5, 4'd1, 16'h0003, 1'b0, 1'b1);
    check("mov_mem", mem[1], 16'h0003);
    check("mov_z", flag_z, 1'b0);
    check("mov_c", flag_c, 1'b1);
    run_instr("nop", 16'h0000, 0, 2, 4'd0, 16'h0000, 1'b0, 1'b0);
    check("nop_c", flag_c, 1'b1);

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    instr       = 16'h9000;
    instr_valid = 1'b1;
    tick();
    check("trap_ill_t1", illegal, 1'b1);
    check("trap_rdy_t1", instr_ready, 1'b0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check($sformatf("trap_halted_t%0d", k), halted, 1'b1);
      check($sformatf("trap_rdy_t%0d", k), instr_ready, 1'b0);
      check($sformatf("trap_ill_t%0d", k), illegal, 1'b0);
    end
    instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("trap_recover_rdy", instr_ready, 1'b1);
    check("trap_recover_halted", halted, 1'b0);
    tick();
    preload(4'd1, 16'd3);
    preload(4'd2, 16'd5);
    run_instr("subb2", 16'h2612, 4, 5, 4'd6, 16'hFFFE, 1'b0, 1'b0);
`else
    run_instr("undef", 16'h9000, 0, 2, 4'd0, 16'h0000, 1'b1, 1'b0);
    check("undef_halted", halted, 1'b0);
    run_instr("ldi2", 16'h5280, 2, 3, 4'd2, 16'hFF80, 1'b0, 1'b0);
`endif

    // Reset during WB of ADD r9,r7,r8: r9 must keep its old value
    preload(4'd7, 16'hFFFF);
    preload(4'd8, 16'h0002);
    preload(4'd9, 16'hBEEF);
    instr       = 16'h1978;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    repeat (3) tick();
    check("rstwb_state", dbg_state, WB);
    check("rstwb_wr_pre", rf_write, 1'b1);
    check("rstwb_c_pre", flag_c, 1'b1);
    reset = 1'b1;
    #1;
    check("rstwb_wr", rf_write, 1'b0);
    check("rstwb_rdy", instr_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("rstwb_mem", mem[9], 16'hBEEF);
    check("rstwb_state_post", dbg_state, IDLE);
    check("rstwb_rdy_post", instr_ready, 1'b1);
    check("rstwb_c_post", flag_c, 1'b0);
    check("rstwb_z_post", flag_z, 1'b0);
    tick();

    // HALT is absorbing
    instr       = 16'hF000;
    instr_valid = 1'b1;
    tick();
    check("halt_t1_halted", halted, 1'b0);
    check("halt_t1_ill", illegal, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("halt_t%0d_halted", k), halted, 1'b1);
      check($sformatf("halt_t%0d_rdy", k), instr_ready, 1'b0);
      check($sformatf("halt_t%0d_wr", k), rf_write, 1'b0);
    end
    instr_valid = 1'b0;

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
